dense_parallel: RTL
===================

Name: dense_parallel

Overview:
- Parametrised successor of the fully-connected layer engine.
- Computes OUT_COUNT neurons over IN_COUNT inputs, evaluating LANES neurons in parallel per input fetch.
- Adds signed fixed-point arithmetic with rounding-free arithmetic shift and output saturation.
- Sits between the AXIS input/output buffers and the external weight/bias LUTs, with the same start/done handshake as the existing dense layer.

Parameters:
IN_COUNT, 16, number of inputs per neuron (>=1)
OUT_COUNT, 10, number of neurons (>=1; need not be a multiple of LANES)
LANES, 2, neurons computed in parallel (1..OUT_COUNT)
DATA_SIZE, 16, signed two's-complement width of inputs, weights, biases and outputs
FRAC_BITS, 8, fractional bits of the Q format (0..DATA_SIZE-1)

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
weightAdr  out  clog2(IN_COUNT*GROUPS)  weight LUT address = g*IN_COUNT + i
weightData  in  LANES*DATA_SIZE  LANES weights; lane k occupies bits [k*DATA_SIZE +: DATA_SIZE]
biasAdr  out  clog2(GROUPS)  bias LUT address = group index g
biasData  in  LANES*DATA_SIZE  LANES biases, same packing as weightData
axisif_start  in  1  single-cycle start request
axisif_done  out  1  one-cycle completion pulse
axisif_bufferIn_adr  out  clog2(IN_COUNT)  input buffer address i
axisif_bufferIn_data  in  DATA_SIZE  input value at axisif_bufferIn_adr
axisif_bufferOut_adr  out  clog2(OUT_COUNT)  output neuron index
axisif_bufferOut_data  out  DATA_SIZE  saturated result
axisif_bufferOut_wr  out  1  output write strobe
Notes:
- GROUPS = ceil(OUT_COUNT/LANES).
- clog2 follows the codebase clogb2 function.

Behaviour:
- Clock/reset: one clock, clk; rst is synchronous and active-high.
- Reset values: FSM returns to IDLE; all counters and accumulators clear to 0; all outputs 0. Reset mid-computation aborts without a done pulse.
- LUTs and buffers: all external LUTs and buffers are combinational reads, so data is valid in the same cycle the address is driven.
- IDLE:
  - Waits for axisif_start.
  - On start: g=0, go to BIAS.
  - start while not IDLE is ignored.
- BIAS:
  - biasAdr=g.
  - Each lane accumulator is loaded with sign-extended bias << FRAC_BITS.
  - i=0; next state MAC.
- MAC:
  - Each cycle, every lane does acc_k += x_i * w_k (signed full-precision product).
  - i increments each cycle.
  - When i==IN_COUNT-1, go to WRITE with lane counter k=0.
  - Takes IN_COUNT cycles.
- Accumulator width: 2*DATA_SIZE + clog2(IN_COUNT) + 1, signed, so no internal overflow.
- WRITE:
  - One lane per cycle: axisif_bufferOut_wr=1, adr = g*LANES+k, data = sat(acc_k >>> FRAC_BITS).
  - Lanes with g*LANES+k >= OUT_COUNT (partial last group) are skipped: no strobe, and they take no cycle.
  - After the last valid lane: if g==GROUPS-1 go to DONE, else g++ and go to BIAS.
- Saturation: results above 2^(DATA_SIZE-1)-1 clamp to that value; results below -2^(DATA_SIZE-1) clamp to that value.
- DONE: axisif_done=1 for exactly one cycle, then IDLE. A start arriving during the DONE cycle is ignored.
- Latency from start to done: GROUPS*(1+IN_COUNT) + OUT_COUNT + 1 cycles.
- Output strobe rules: axisif_bufferOut_wr is high only in WRITE; adr/data are 0 when the strobe is low.

Optional Feature:
- Macro DENSE_PARALLEL_RELU_EN.
- Defined: after saturation, negative results are written as 0 (fused ReLU). Timing is unchanged.
- Undefined: signed saturated results are written as-is.

Test Plan:
- IN_COUNT=4, OUT_COUNT=4, LANES=2, FRAC_BITS=8; inputs all 1.0 (256); weights all 0.5 (128); biases 0 -> each output = 2.0 (512); 4 strobes at adr 0..3; done at cycle 2*(1+4)+4+1=15 after start.
- OUT_COUNT=5, LANES=2 -> GROUPS=3; lane 1 of group 2 never strobes; adr 5 is never written; done follows the latency formula.
- Inputs 127.0 and weights 127.0 (Q8.8 maximum) -> output saturates to 0x7FFF. Negated weights -> 0x8000, or 0x0000 with DENSE_PARALLEL_RELU_EN.
- Bias -1.0 (0xFF00) with zero weights -> output 0xFF00 without the macro, 0x0000 with it.
- Assert rst during MAC of group 1 -> next cycle all outputs 0, no done pulse; a fresh start produces the full correct result set.
- Pulse axisif_start during MAC and during the DONE cycle -> ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/dense_parallel.sv
// Fully-connected layer engine: LANES neurons per input fetch, signed Q-format MAC
// with output saturation. Define DENSE_PARALLEL_RELU_EN to clamp negative results to 0.
module dense_parallel #(
    parameter int IN_COUNT  = 16,
    parameter int OUT_COUNT = 10,
    parameter int LANES     = 2,
    parameter int DATA_SIZE = 16,
    parameter int FRAC_BITS = 8,
    localparam int GROUPS = (OUT_COUNT + LANES - 1) / LANES,
    localparam int WA_W   = (IN_COUNT * GROUPS > 1) ? $clog2(IN_COUNT * GROUPS) : 1,
    localparam int BA_W   = (GROUPS > 1) ? $clog2(GROUPS) : 1,
    localparam int IN_W   = (IN_COUNT > 1) ? $clog2(IN_COUNT) : 1,
    localparam int OA_W   = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic [WA_W-1:0]                weightAdr,
    input  logic [LANES*DATA_SIZE-1:0]     weightData,
    output logic [BA_W-1:0]                biasAdr,
    input  logic [LANES*DATA_SIZE-1:0]     biasData,
    input  logic                           axisif_start,
    output logic                           axisif_done,
    output logic [IN_W-1:0]                axisif_bufferIn_adr,
    input  logic [DATA_SIZE-1:0]           axisif_bufferIn_data,
    output logic [OA_W-1:0]                axisif_bufferOut_adr,
    output logic [DATA_SIZE-1:0]           axisif_bufferOut_data,
    output logic                           axisif_bufferOut_wr
);
    localparam int K_W   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int ACC_W = 2 * DATA_SIZE + IN_W + 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - DATA_SIZE + 1){1'b0}}, {(DATA_SIZE - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - DATA_SIZE + 1){1'b1}}, {(DATA_SIZE - 1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_WRITE, S_DONE} state_t;

    state_t          state_q;
    logic [BA_W-1:0] g_q;
    logic [IN_W-1:0] i_q;
    logic [K_W-1:0]  k_q;

    logic [LANES-1:0][ACC_W-1:0] acc_all;
    logic signed [DATA_SIZE-1:0] x_s;
    logic [31:0]                 out_idx;
    logic                        last_lane, last_group, last_in;

    assign x_s        = $signed(axisif_bufferIn_data);
    assign out_idx    = 32'(g_q) * 32'(LANES) + 32'(k_q);
    // A lane is the last of its group either by position or because the next neuron does not exist.
    assign last_lane  = (32'(k_q) == 32'(LANES - 1)) || (out_idx + 32'd1 >= 32'(OUT_COUNT));
    assign last_group = (32'(g_q) == 32'(GROUPS - 1));
    assign last_in    = (32'(i_q) == 32'(IN_COUNT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            g_q     <= '0;
            i_q     <= '0;
            k_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (axisif_start) begin
                        g_q     <= '0;
                        state_q <= S_BIAS;
                    end
                end
                S_BIAS: begin
                    i_q     <= '0;
                    state_q <= S_MAC;
                end
                S_MAC: begin
                    if (last_in) begin
                        i_q     <= '0;
                        k_q     <= '0;
                        state_q <= S_WRITE;
                    end else begin
                        i_q <= i_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (last_lane) begin
                        k_q <= '0;
                        if (last_group) begin
                            g_q     <= '0;
                            state_q <= S_DONE;
                        end else begin
                            g_q     <= g_q + 1'b1;
                            state_q <= S_BIAS;
                        end
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [DATA_SIZE-1:0]   w_s;
            logic signed [DATA_SIZE-1:0]   b_s;
            logic signed [2*DATA_SIZE-1:0] prod;
            logic signed [ACC_W-1:0]       acc_q;
            logic signed [ACC_W-1:0]       acc_d;

            assign w_s  = $signed(weightData[gi*DATA_SIZE +: DATA_SIZE]);
            assign b_s  = $signed(biasData[gi*DATA_SIZE +: DATA_SIZE]);
            assign prod = x_s * w_s;

            always_comb begin
                acc_d = acc_q;
                if (state_q == S_BIAS) begin
                    acc_d = ACC_W'(b_s) <<< FRAC_BITS;
                end else if (state_q == S_MAC) begin
                    acc_d = acc_q + ACC_W'(prod);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_d;
                end
            end

            assign acc_all[gi] = acc_q;
        end
    endgenerate

    logic signed [ACC_W-1:0] acc_sel;
    logic signed [ACC_W-1:0] shifted;
    logic [DATA_SIZE-1:0]    result;

    assign acc_sel = $signed(acc_all[k_q]);

    always_comb begin
        shifted = acc_sel >>> FRAC_BITS;
        if (shifted > SAT_MAX) begin
            result = SAT_MAX[DATA_SIZE-1:0];
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[DATA_SIZE-1:0];
        end else begin
            result = shifted[DATA_SIZE-1:0];
        end
`ifdef DENSE_PARALLEL_RELU_EN
        if (result[DATA_SIZE-1]) begin
            result = '0;
        end
`endif
    end

    assign weightAdr             = WA_W'(32'(g_q) * 32'(IN_COUNT) + 32'(i_q));
    assign biasAdr               = g_q;
    assign axisif_bufferIn_adr   = i_q;
    assign axisif_bufferOut_wr   = (state_q == S_WRITE);
    assign axisif_bufferOut_adr  = axisif_bufferOut_wr ? OA_W'(out_idx) : '0;
    assign axisif_bufferOut_data = axisif_bufferOut_wr ? result : '0;
    assign axisif_done           = (state_q == S_DONE);

endmodule
